// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: datapath widths, MEM-stage FSM states
// and the default memory-wait watchdog limit.
package mips_pkg;
  localparam int DATA_W       = 32;
  localparam int REG_W        = 5;
  localparam int MAX_WAIT_DEF = 15;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_t;
endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for the MEM stage: synchronous clear, count enable, and a
// terminal-count flag when the count reaches MAX_WAIT-1; no handshake of its own.
module mem_wait_timer
  import mips_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] wcnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt <= '0;
    end else if (clr) begin
      wcnt <= '0;
    end else if (en) begin
      wcnt <= wcnt + 1'b1;
    end
  end

  assign tc = (wcnt == CNT_W'(MAX_WAIT - 1));
endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory controller: result lands in MEM/WB one edge after the ack
// (or after MAX_WAIT stalled cycles on timeout); stall_MEM holds upstream while waiting.
module mem_access_ctrl
  import mips_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] aluRes_MEM,
  input  logic [DATA_W-1:0] writeData_MEM,
  input  logic [REG_W-1:0]  writeReg_MEM,
  input  logic              memToReg_MEM,
  input  logic              memWrite_MEM,
  input  logic              regWrite_MEM,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              stall_MEM,
  output logic [DATA_W-1:0] readData_WB,
  output logic [DATA_W-1:0] aluRes_WB,
  output logic [REG_W-1:0]  writeReg_WB,
  output logic              memToReg_WB,
  output logic              regWrite_WB,
  output logic              err_WB
);
  mem_state_t state, state_nxt;
  logic memop;
  logic tc;
  logic complete;
  logic timeout;
  logic tmr_clr;
  logic tmr_en;

  assign memop      = memToReg_MEM | memWrite_MEM;
  assign dmem_we    = memWrite_MEM;
  assign dmem_addr  = aluRes_MEM;
  assign dmem_wdata = writeData_MEM;

  mem_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (tmr_clr),
    .en  (tmr_en),
    .tc  (tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= MEM_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Ack has priority over the watchdog on the terminal-count cycle.
  always_comb begin
    state_nxt = state;
    dmem_req  = 1'b0;
    complete  = 1'b0;
    timeout   = 1'b0;
    tmr_clr   = 1'b0;
    tmr_en    = 1'b0;
    case (state)
      MEM_IDLE: begin
        dmem_req = memop;
        complete = !memop || dmem_ack;
        tmr_clr  = 1'b1;
        if (memop && !dmem_ack) begin
          state_nxt = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        dmem_req = 1'b1;
        complete = dmem_ack || tc;
        timeout  = !dmem_ack && tc;
        tmr_en   = !complete;
        if (complete) begin
          state_nxt = MEM_IDLE;
        end
      end
      default: begin
        state_nxt = MEM_IDLE;
      end
    endcase
  end

  assign stall_MEM = dmem_req && !complete;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      readData_WB <= '0;
      aluRes_WB   <= '0;
      writeReg_WB <= '0;
      memToReg_WB <= 1'b0;
      regWrite_WB <= 1'b0;
      err_WB      <= 1'b0;
    end else if (complete) begin
      aluRes_WB   <= aluRes_MEM;
      writeReg_WB <= writeReg_MEM;
      memToReg_WB <= memToReg_MEM;
      regWrite_WB <= regWrite_MEM;
      err_WB      <= timeout;
      readData_WB <= (memop && dmem_ack && !memWrite_MEM) ? dmem_rdata : '0;
    end else begin
      // Bubble: kill the control bits, leave the data fields as they were.
      memToReg_WB <= 1'b0;
      regWrite_WB <= 1'b0;
      err_WB      <= 1'b0;
    end
  end
endmodule
